lab2_4_bit_serial_adder: RTL and testbench



---
 rtl/lab2_4_bit_serial_adder.sv | 93 +++++++++
 tb/tb_lab2_4_bit_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lab2_4_bit_serial_adder.sv
// Purpose: bit-serial adder, one bit per cycle LSB first, {cout,S} = A + B + cin.
// Latency: start accepted at edge N -> done high for the cycle after edge N+WIDTH.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE.
module lab2_4_bit_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic             last_bit;

    // One full-adder slice on the current LSBs; r_nxt is the result register after this bit.
    always_comb begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        r_nxt     = {sum_bit, r_sr[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // Status flags decode straight from the state flop, so reset clears them at once.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // FSM plus datapath; operands are captured only on the accepting edge so later
    // changes on A/B/cin cannot disturb an addition already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    r_sr  <= r_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // Publish the result only when the final bit is in, so S/cout
                        // hold the previous answer throughout IDLE and RUN.
                        S     <= r_nxt;
                        cout  <= carry_nxt;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_4_bit_serial_adder.sv
// Purpose: randomized and directed stimulus for the serial adder with a queue scoreboard.
// Latency: expected completion cycle is carried with each queued result.
// Backpressure: n/a (bench).
module tb_lab2_4_bit_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic [W-1:0] S;
    logic         cout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [W:0] model_last;
    int         cyc;
    int         errors;
    int         checks;
    int         busy_run;

    lab2_4_bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .S     (S),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected completions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition, WIDTH+1 bits wide.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        ref_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Issue one operation; during the RUN cycles inputs are scrambled (or start is held).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input bit hold);
        exp_t e;
        @(negedge clk);
        A = a; B = b; cin = ci; start = 1'b1;
        e.res = ref_sum(a, b, ci);
        e.cyc = cyc + 1 + W;
        q.push_back(e);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
            start = hold ? 1'b1 : 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Monitor: pops on every done, checks latency, result, busy length, and that
    // S/cout hold the last completed result on every other cycle.
    initial begin
        exp_t h;
        busy_run = 0;
        forever begin
            @(posedge clk);
            #1;
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                h = q.pop_front();
                chk("done_missing", 32'd0, 32'd1);
                model_last = h.res;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    h = q.pop_front();
                    chk("done_latency", cyc, h.cyc);
                    chk("sum_cout", {27'd0, cout, S}, {27'd0, h.res});
                    chk("busy_length", busy_run, W);
                    model_last = h.res;
                end
            end else begin
                chk("hold_sum_cout", {27'd0, cout, S}, {27'd0, model_last});
            end
            busy_run = busy ? busy_run + 1 : 0;
        end
    end

    initial begin
        int wait_cyc;
        cyc = 0; errors = 0; checks = 0; model_last = '0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        #1;
        chk("reset_S", {28'd0, S}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(4'b0000, 4'b1100, 1'b1, 1'b0); idle(3);
        do_op(4'b0111, 4'b1010, 1'b1, 1'b0); idle(2);
        do_op(4'b1111, 4'b1111, 1'b1, 1'b0); idle(1);
        do_op(4'b0001, 4'b0010, 1'b1, 1'b0); idle(4);
        // Start held high: back-to-back operations every W+1 cycles.
        do_op(4'b0011, 4'b0110, 1'b1, 1'b1);
        do_op(4'b1000, 4'b0001, 1'b0, 1'b1); idle(3);

        // Reset asserted between edges in the middle of RUN.
        @(negedge clk);
        A = 4'b1011; B = 4'b0110; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        model_last = '0;
        #1;
        chk("midrun_reset_S", {28'd0, S}, 32'd0);
        chk("midrun_reset_cout", {31'd0, cout}, 32'd0);
        chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'b0101, 4'b0110, 1'b0, 1'b0); idle(2);

        // Random operations with random gaps (including back-to-back).
        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            idle($urandom_range(0, 3));
        end

        // Exhaustive sweep of every operand/carry combination.
        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                for (int c = 0; c < 2; c++)
                    do_op(W'(a), W'(b), 1'(c), 1'b0);
        idle(1);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("drain_timeout", q.size(), 32'd0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
